// File: rtl/nco_phase_accumulator.sv
// Phase accumulator front end for the sine voice: a tuning word is accumulated on
// each sample tick; the top bits drive the quarter-wave stage. Supports gating, hard sync and glide.
module nco_phase_accumulator #(
   parameter int ACC_W       = 32,
   parameter int PHASE_W     = 16,
   parameter int GLIDE_SHIFT = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               tick,
   input  logic               gate,
   input  logic               sync,
   input  logic               glide_en,
   input  logic               tw_valid,
   output logic               tw_ready,
   input  logic [ACC_W-1:0]   tw_data,
   output logic [PHASE_W-1:0] phase_out,
   output logic               phase_valid,
   output logic               wrap,
   output logic [1:0]         state_dbg,
   output logic [ACC_W-1:0]   inc_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GLIDE = 2'd2} state_t;

   state_t               state, state_nxt;
   logic [1:0]           rst_q;
   logic                 rst_n;
   logic [ACC_W-1:0]     acc, cur_inc, target, tw_hold;
   logic                 pending;
   logic [ACC_W-1:0]     acc_nxt, inc_nxt, target_nxt, step;
   logic [PHASE_W-1:0]   phase_nxt;
   logic                 valid_nxt, wrap_nxt;
   logic [ACC_W:0]       sum;
   logic signed [ACC_W:0] diff, shifted;
   logic                 apply, at_target;

   // Reset asserts immediately but is released only after two clean clock edges.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_q <= 2'b00;
      else          rst_q <= {rst_q[0], 1'b1};
   end
   assign rst_n = rst_q[1];

   // Handshake: a word is taken when tw_valid && tw_ready at a clk edge; tw_ready is low
   // while a word is held and waiting for the next tick to apply it.
   assign tw_ready  = !pending;
   assign apply     = tick && pending;
   assign at_target = (cur_inc == target);
   assign sum       = {1'b0, acc} + {1'b0, cur_inc};
   assign diff      = $signed({1'b0, target}) - $signed({1'b0, cur_inc});
   assign shifted   = diff >>> GLIDE_SHIFT;
   assign state_dbg = state;
   assign inc_dbg   = cur_inc;

   // Small differences still move by one so the glide always lands on the target.
   always_comb begin
      step = shifted[ACC_W-1:0];
      if (shifted == '0) step = diff[ACC_W] ? '1 : {{(ACC_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (tick) begin
         if (!gate)                               state_nxt = IDLE;
         else if (state == IDLE)                  state_nxt = RUN;
         else if (apply)                          state_nxt = glide_en ? GLIDE : RUN;
         else if (state == GLIDE && at_target)    state_nxt = RUN;
      end
   end

   always_comb begin
      acc_nxt    = acc;
      inc_nxt    = cur_inc;
      target_nxt = target;
      phase_nxt  = phase_out;
      valid_nxt  = 1'b0;
      wrap_nxt   = 1'b0;
      if (tick) begin
         if (gate) begin
            valid_nxt = 1'b1;
            if (state == IDLE) begin
               acc_nxt   = '0;
               phase_nxt = '0;
            end else begin
               if (sync) begin
                  acc_nxt   = '0;
                  phase_nxt = '0;
                  wrap_nxt  = 1'b1;
               end else begin
                  acc_nxt   = sum[ACC_W-1:0];
                  phase_nxt = sum[ACC_W-1 -: PHASE_W];
                  wrap_nxt  = sum[ACC_W];
               end
               if (state == GLIDE && !at_target) inc_nxt = cur_inc + step;
            end
         end
         if (apply) begin
            target_nxt = tw_hold;
            if (!gate || state == IDLE || !glide_en) inc_nxt = tw_hold;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc         <= '0;
         cur_inc     <= '0;
         target      <= '0;
         tw_hold     <= '0;
         pending     <= 1'b0;
         phase_out   <= '0;
         phase_valid <= 1'b0;
         wrap        <= 1'b0;
      end else begin
         acc         <= acc_nxt;
         cur_inc     <= inc_nxt;
         target      <= target_nxt;
         phase_out   <= phase_nxt;
         phase_valid <= valid_nxt;
         wrap        <= wrap_nxt;
         if (tw_valid && tw_ready) begin
            tw_hold <= tw_data;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Directed bench for nco_phase_accumulator: expected {wrap, phase} words are queued as
// ticks are driven and checked when phase_valid appears.
module tb_nco_phase_accumulator;

   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_GLIDE = 2'd2;

   logic        clk, reset_n, tick, gate, sync, glide_en, tw_valid, tw_ready;
   logic [31:0] tw_data, inc_dbg;
   logic [15:0] phase_out;
   logic        phase_valid, wrap;
   logic [1:0]  state_dbg;

   logic [16:0] exp_q[$];
   logic [16:0] mon_e;
   int          checks = 0;
   int          errors = 0;

   logic [31:0] m_acc, m_inc, m_tgt, prev;
   bit          m_glide;

   nco_phase_accumulator dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .gate(gate), .sync(sync),
      .glide_en(glide_en), .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_data(tw_data),
      .phase_out(phase_out), .phase_valid(phase_valid), .wrap(wrap),
      .state_dbg(state_dbg), .inc_dbg(inc_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every phase_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n && phase_valid) begin
         if (exp_q.size() == 0) begin
            check("extra_valid", 64'(phase_valid), 64'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("phase_wrap", 64'({wrap, phase_out}), 64'(mon_e));
         end
      end
   end

   task automatic offer(input logic [31:0] d);
      @(negedge clk);
      check("ready_before_offer", 64'(tw_ready), 64'(1));
      tw_valid = 1'b1;
      tw_data  = d;
      @(negedge clk);
      tw_valid = 1'b0;
      #1;
      check("ready_after_accept", 64'(tw_ready), 64'(0));
   endtask

   task automatic tick_expect(input logic [15:0] p, input logic w);
      @(negedge clk);
      exp_q.push_back({w, p});
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic tick_silent();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      #1;
      check("silent_no_valid", 64'(phase_valid), 64'(0));
   endtask

   task automatic drain(input string tag);
      @(negedge clk);
      check(tag, 64'(exp_q.size()), 64'(0));
   endtask

   // Reference glide arithmetic; the increment used is the one before this tick's update.
   task automatic model_tick(input bit apply_glide, input logic [31:0] new_tgt);
      logic [32:0] s;
      longint      d, st;
      @(negedge clk);
      s = {1'b0, m_acc} + {1'b0, m_inc};
      exp_q.push_back({s[32], s[31:16]});
      tick = 1'b1;
      m_acc = s[31:0];
      if (m_glide) begin
         if (m_inc == m_tgt) m_glide = 1'b0;
         else begin
            d  = longint'(m_tgt) - longint'(m_inc);
            st = d >>> 6;
            if (st == 0) st = (d < 0) ? -1 : 1;
            m_inc = m_inc + st[31:0];
         end
      end
      if (apply_glide) begin
         m_tgt   = new_tgt;
         m_glide = 1'b1;
      end
      @(negedge clk);
      tick = 1'b0;
      #1;
      check("model_inc", 64'(inc_dbg), 64'(m_inc));
   endtask

   task automatic glide_loop(input logic [31:0] tgt, input bit up);
      int k;
      k = 0;
      while (m_glide && k < 4000) begin
         prev = inc_dbg;
         model_tick(1'b0, 32'h0);
         if (up) begin
            check("glide_up_monotonic", 64'(inc_dbg >= prev), 64'(1));
            check("glide_up_no_overshoot", 64'(inc_dbg <= tgt), 64'(1));
         end else begin
            check("glide_dn_monotonic", 64'(inc_dbg <= prev), 64'(1));
            check("glide_dn_no_overshoot", 64'(inc_dbg >= tgt), 64'(1));
         end
         k++;
      end
      check("glide_done_state", 64'(state_dbg), 64'(S_RUN));
      check("glide_done_inc", 64'(inc_dbg), 64'(tgt));
   endtask

   initial begin
      reset_n = 1'b0; tick = 1'b0; gate = 1'b0; sync = 1'b0;
      glide_en = 1'b0; tw_valid = 1'b0; tw_data = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_phase", 64'(phase_out), 64'(0));
      check("reset_valid", 64'(phase_valid), 64'(0));
      check("reset_wrap", 64'(wrap), 64'(0));
      check("reset_ready", 64'(tw_ready), 64'(1));
      check("reset_state", 64'(state_dbg), 64'(S_IDLE));
      check("reset_inc", 64'(inc_dbg), 64'(0));

      // Reset dropped mid-RUN, right after a tick that also accepted a word.
      offer(32'h0100_0000);
      gate = 1'b1;
      tick_expect(16'h0000, 1'b0);
      tick_expect(16'h0100, 1'b0);
      tick_expect(16'h0200, 1'b0);
      @(negedge clk);
      tick = 1'b1; tw_valid = 1'b1; tw_data = 32'h0300_0000;
      @(posedge clk);
      #1;
      check("pre_reset_valid", 64'(phase_valid), 64'(1));
      check("pre_reset_phase", 64'(phase_out), 64'(16'h0300));
      check("same_edge_accept", 64'(tw_ready), 64'(0));
      #1 reset_n = 1'b0;
      #1;
      check("async_reset_phase", 64'(phase_out), 64'(0));
      check("async_reset_valid", 64'(phase_valid), 64'(0));
      check("async_reset_ready", 64'(tw_ready), 64'(1));
      check("async_reset_state", 64'(state_dbg), 64'(S_IDLE));
      @(negedge clk);
      tick = 1'b0; tw_valid = 1'b0; gate = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Full ramp with a carry on the 257th tick.
      offer(32'h0100_0000);
      gate = 1'b1;
      for (int i = 0; i <= 256; i++) tick_expect(16'((i * 256) & 16'hFFFF), i == 256);
      drain("drain_ramp");

      // Second offer stalls until the tick edge that applies the first.
      offer(32'h4000_0000);
      @(negedge clk);
      tw_valid = 1'b1; tw_data = 32'h8000_0000;
      #1 check("second_offer_stalls", 64'(tw_ready), 64'(0));
      @(negedge clk);
      check("stall_holds", 64'(tw_ready), 64'(0));
      gate = 1'b0; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      #1 check("ready_after_tick", 64'(tw_ready), 64'(1));
      check("first_word_applied", 64'(inc_dbg), 64'(32'h4000_0000));
      @(negedge clk);
      tw_valid = 1'b0;
      #1 check("second_offer_taken", 64'(tw_ready), 64'(0));
      gate = 1'b1;
      tick_expect(16'h0000, 1'b0);
      tick_expect(16'h8000, 1'b0);
      tick_expect(16'h0000, 1'b1);
      tick_expect(16'h8000, 1'b0);
      tick_expect(16'h0000, 1'b1);
      tick_expect(16'h8000, 1'b0);
      gate = 1'b0;
      tick_silent();
      check("gate_off_phase_holds", 64'(phase_out), 64'(16'h8000));
      check("gate_off_state", 64'(state_dbg), 64'(S_IDLE));
      gate = 1'b1;
      tick_expect(16'h0000, 1'b0);
      tick_expect(16'h8000, 1'b0);
      drain("drain_half");

      // Hard sync.
      offer(32'h1234_5678);
      gate = 1'b0;
      tick_silent();
      gate = 1'b1;
      tick_expect(16'h0000, 1'b0);
      tick_expect(16'h1234, 1'b0);
      sync = 1'b1;
      tick_expect(16'h0000, 1'b1);
      sync = 1'b0;
      tick_expect(16'h1234, 1'b0);
      drain("drain_sync");

      // Glide up then down.
      offer(32'h0100_0000);
      gate = 1'b0;
      tick_silent();
      gate = 1'b1;
      tick_expect(16'h0000, 1'b0);
      m_acc = '0; m_inc = 32'h0100_0000; m_tgt = 32'h0100_0000; m_glide = 1'b0;
      glide_en = 1'b1;
      offer(32'h0200_0000);
      model_tick(1'b1, 32'h0200_0000);
      check("glide_entered", 64'(state_dbg), 64'(S_GLIDE));
      model_tick(1'b0, 32'h0);
      check("first_step_up", 64'(inc_dbg), 64'(32'h0104_0000));
      glide_loop(32'h0200_0000, 1'b1);
      offer(32'h0100_0000);
      model_tick(1'b1, 32'h0100_0000);
      model_tick(1'b0, 32'h0);
      check("first_step_down", 64'(inc_dbg), 64'(32'h01FC_0000));
      glide_loop(32'h0100_0000, 1'b0);
      drain("drain_glide");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
